// File: rtl/latch_write_sequencer_pkg.sv
// ============================================================================
// Module      : latch_write_sequencer_pkg
// Description : Shared state encoding and timer sizing for the latch write
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package latch_write_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_PULSE = 2'd2,
        ST_HOLD  = 2'd3
    } seq_state_t;

    // The timer only ever holds (interval - 1), so clog2 of the longest interval suffices.
    function automatic int timer_width(input int setup_cyc, input int pulse_cyc, input int hold_cyc);
        int m;
        m = setup_cyc;
        if (pulse_cyc > m) m = pulse_cyc;
        if (hold_cyc > m)  m = hold_cyc;
        return ($clog2(m) < 1) ? 1 : $clog2(m);
    endfunction

endpackage

`default_nettype wire

// File: rtl/latch_write_sequencer_phase_timer.sv
// ============================================================================
// Module      : phase_timer
// Description : Loadable, non-wrapping down-counter with a zero flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer #(
    parameter int TW = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_val,
    output logic          o_zero
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

`default_nettype wire

// File: rtl/latch_write_sequencer.sv
// ============================================================================
// Module      : latch_write_sequencer
// Description : Presents a word on D, then pulses LE with programmable setup,
//               pulse-width and hold intervals; signals Done on completion.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module latch_write_sequencer
    import latch_write_sequencer_pkg::*;
#(
    parameter int WIDTH     = 1,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int HOLD_CYC  = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] D,
    output logic             LE,
    output logic             Busy,
    output logic             Done
);

    localparam int            c_tw       = timer_width(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam logic [c_tw-1:0] c_setup_ld = c_tw'(SETUP_CYC - 1);
    localparam logic [c_tw-1:0] c_pulse_ld = c_tw'(PULSE_CYC - 1);
    localparam logic [c_tw-1:0] c_hold_ld  = c_tw'(HOLD_CYC - 1);

    seq_state_t      r_state;
    logic            w_accept;
    logic            w_zero;
    logic            w_load;
    logic [c_tw-1:0] w_load_val;

    assign w_accept = In_Valid && (r_state == ST_IDLE);
    assign In_Ready = (r_state == ST_IDLE);
    assign Busy     = (r_state != ST_IDLE);

    // The timer reloads only on the transitions into a timed phase.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            ST_IDLE: begin
                w_load     = w_accept;
                w_load_val = c_setup_ld;
            end
            ST_SETUP: begin
                w_load     = w_zero;
                w_load_val = c_pulse_ld;
            end
            ST_PULSE: begin
                w_load     = w_zero;
                w_load_val = c_hold_ld;
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = '0;
            end
        endcase
    end

    phase_timer #(
        .TW (c_tw)
    ) u_phase_timer (
        .clk        (Clk),
        .rst        (Rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_zero     (w_zero)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            r_state <= ST_IDLE;
            D       <= '0;
            LE      <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        D       <= In_Data;
                        r_state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (w_zero) begin
                        LE      <= 1'b1;
                        r_state <= ST_PULSE;
                    end
                end
                ST_PULSE: begin
                    if (w_zero) begin
                        LE      <= 1'b0;
                        r_state <= ST_HOLD;
                    end
                end
                default: begin
                    if (w_zero) begin
                        Done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_latch_write_sequencer.sv
// ============================================================================
// Module      : tb_latch_write_sequencer
// Description : Directed, table-driven bench for latch_write_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_latch_write_sequencer;

    localparam int S0 = 2;
    localparam int P0 = 4;
    localparam int H0 = 2;

    typedef struct {
        logic le;
        logic d;
        logic done;
        logic busy;
        logic rdy;
    } vec0_t;

    typedef struct {
        logic       le;
        logic [7:0] d;
        logic       done;
        logic       busy;
        logic       rdy;
    } vec1_t;

    logic       Clk;
    logic       Rst;
    logic       din0, v0, rdy0, d0, le0, busy0, done0;
    logic [7:0] din1, d1;
    logic       v1, rdy1, le1, busy1, done1;
    logic       q0;

    int checks   = 0;
    int failures = 0;

    int   m_age, m_low, m_hi, m_rises;
    logic m_prev_d, m_prev_le;

    latch_write_sequencer #(
        .WIDTH(1), .SETUP_CYC(S0), .PULSE_CYC(P0), .HOLD_CYC(H0)
    ) dut0 (
        .Clk(Clk), .Rst(Rst), .In_Data(din0), .In_Valid(v0), .In_Ready(rdy0),
        .D(d0), .LE(le0), .Busy(busy0), .Done(done0)
    );

    latch_write_sequencer #(
        .WIDTH(8), .SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(1)
    ) dut1 (
        .Clk(Clk), .Rst(Rst), .In_Data(din1), .In_Valid(v1), .In_Ready(rdy1),
        .D(d1), .LE(le1), .Busy(busy1), .Done(done1)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Step to just after the next rising edge; the downstream latch follows D while LE is high.
    task automatic tick();
        @(posedge Clk);
        #1;
        if (le0) q0 = d0;
    endtask

    // Protocol monitor on dut0: setup, pulse width, hold and one LE rise per Done.
    always @(negedge Clk) begin
        if (Rst) begin
            m_prev_d  = d0;
            m_prev_le = 1'b0;
            m_age     = 100;
            m_low     = 100;
            m_hi      = 0;
            m_rises   = 0;
        end else begin
            if (d0 != m_prev_d) begin
                check("hold_cycles", 32'(m_low >= H0), 32'd1);
                m_age = 0;
            end else begin
                m_age++;
            end
            if (le0 && !m_prev_le) begin
                check("setup_cycles", 32'(m_age >= S0), 32'd1);
                m_rises++;
            end
            if (!le0 && m_prev_le) check("le_width", 32'(m_hi), 32'(P0));
            if (done0) begin
                check("le_rise_per_done", 32'(m_rises), 32'd1);
                m_rises = 0;
            end
            if (le0) begin
                m_hi++;
                m_low = 0;
            end else begin
                m_low++;
                m_hi = 0;
            end
            m_prev_d  = d0;
            m_prev_le = le0;
        end
    end

    vec0_t t0 [0:10];
    vec1_t t1 [0:5];
    logic  wds [0:2];

    initial begin
        Rst  = 1'b1;
        v0   = 1'b0;
        din0 = 1'b0;
        v1   = 1'b0;
        din1 = 8'h00;
        q0   = 1'b0;

        // Defaults, word 1 accepted at cycle 0.
        t0[0]  = '{le:1'b0, d:1'b0, done:1'b0, busy:1'b0, rdy:1'b1};
        t0[1]  = '{le:1'b0, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[2]  = '{le:1'b0, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[3]  = '{le:1'b1, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[4]  = '{le:1'b1, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[5]  = '{le:1'b1, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[6]  = '{le:1'b1, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[7]  = '{le:1'b0, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[8]  = '{le:1'b0, d:1'b1, done:1'b0, busy:1'b1, rdy:1'b0};
        t0[9]  = '{le:1'b0, d:1'b1, done:1'b1, busy:1'b0, rdy:1'b1};
        t0[10] = '{le:1'b0, d:1'b1, done:1'b0, busy:1'b0, rdy:1'b1};

        // All intervals 1, word 8'hA5 accepted at cycle 0.
        t1[0] = '{le:1'b0, d:8'h00, done:1'b0, busy:1'b0, rdy:1'b1};
        t1[1] = '{le:1'b0, d:8'hA5, done:1'b0, busy:1'b1, rdy:1'b0};
        t1[2] = '{le:1'b1, d:8'hA5, done:1'b0, busy:1'b1, rdy:1'b0};
        t1[3] = '{le:1'b0, d:8'hA5, done:1'b0, busy:1'b1, rdy:1'b0};
        t1[4] = '{le:1'b0, d:8'hA5, done:1'b1, busy:1'b0, rdy:1'b1};
        t1[5] = '{le:1'b0, d:8'hA5, done:1'b0, busy:1'b0, rdy:1'b1};

        wds[0] = 1'b1;
        wds[1] = 1'b0;
        wds[2] = 1'b1;

        tick();
        tick();
        check("reset_outputs", 32'({d0, le0, done0, busy0, rdy0, d1, le1, done1, busy1, rdy1}),
              32'({1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1}));
        Rst = 1'b0;
        tick();

        // Single write with default timing.
        v0   = 1'b1;
        din0 = 1'b1;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) tick();
            if (c == 1) v0 = 1'b0;
            check($sformatf("default_c%0d", c), 32'({le0, d0, done0, busy0, rdy0}),
                  32'({t0[c].le, t0[c].d, t0[c].done, t0[c].busy, t0[c].rdy}));
            if (c == 3) check("latch_q_c3", 32'(q0), 32'd1);
        end

        // Back-to-back with In_Valid held high, words 1, 0, 1.
        v0   = 1'b1;
        din0 = 1'b1;
        for (int c = 0; c <= 27; c++) begin
            if (c > 0) tick();
            if (c == 1)  din0 = 1'b0;
            if (c == 10) din0 = 1'b1;
            if (c == 19) v0 = 1'b0;
            if (c >= 1) begin
                check($sformatf("b2b_d_c%0d", c), 32'(d0), 32'(wds[(c - 1) / 9]));
                check($sformatf("b2b_done_c%0d", c), 32'(done0), 32'(c == 9 || c == 18 || c == 27));
            end
            if (c == 3 || c == 12 || c == 21)
                check($sformatf("b2b_q_c%0d", c), 32'(q0), 32'(wds[(c - 3) / 9]));
        end

        // In_Data toggling while busy must not disturb D.
        v0   = 1'b1;
        din0 = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            if (c > 0) begin
                tick();
                v0   = 1'b0;
                din0 = ~din0;
                check($sformatf("toggle_d_c%0d", c), 32'(d0), 32'd0);
                check($sformatf("toggle_done_c%0d", c), 32'(done0), 32'(c == 9));
            end
        end
        check("toggle_q", 32'(q0), 32'd0);

        // Reset during PULSE.
        v0   = 1'b1;
        din0 = 1'b1;
        tick();
        v0 = 1'b0;
        tick();
        tick();
        tick();
        check("pre_reset_le", 32'({le0, d0}), 32'({1'b1, 1'b1}));
        Rst = 1'b1;
        #1;
        check("async_reset_le_d", 32'({le0, d0, busy0, rdy0}), 32'({1'b0, 1'b0, 1'b0, 1'b1}));
        tick();
        Rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            check($sformatf("post_reset_c%0d", c), 32'({done0, rdy0, le0}), 32'({1'b0, 1'b1, 1'b0}));
        end

        // Minimum intervals on the 8-bit instance.
        v1   = 1'b1;
        din1 = 8'hA5;
        for (int c = 0; c <= 5; c++) begin
            if (c > 0) tick();
            if (c == 1) begin
                v1   = 1'b0;
                din1 = 8'h3C;
            end
            check($sformatf("min_c%0d", c), 32'({le1, d1, done1, busy1, rdy1}),
                  32'({t1[c].le, t1[c].d, t1[c].done, t1[c].busy, t1[c].rdy}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/latch_write_sequencer.md
# latch_write_sequencer

Write sequencer that sits directly upstream of the team's level-sensitive D latch stage and drives its data and gate inputs. It accepts a word over a valid/ready handshake, presents it on `D`, waits a programmable setup interval, and raises the latch gate `LE` for a programmable pulse width. It then holds `D` stable for a programmable hold interval and signals completion. This guarantees setup, hold and minimum gate-width margins at the latch, all counted in `Clk` cycles.

## Interface
- `WIDTH`, 1, data width of `In_Data` and `D`.
- `SETUP_CYC`, 2, cycles `D` is stable before `LE` rises; legal range ≥1.
- `PULSE_CYC`, 4, cycles `LE` is high; legal range ≥1.
- `HOLD_CYC`, 2, cycles `D` is stable after `LE` falls; legal range ≥1.
- `Clk`  input  1  single clock; all state updates on the rising edge.
- `Rst`  input  1  asynchronous, active-high reset.
- `In_Data`  input  WIDTH  word to be written into the latch.
- `In_Valid`  input  1  `In_Data` is valid.
- `In_Ready`  output  1  block can accept a word; equals (state == IDLE).
- `D`  output  WIDTH  latch data input; registered.
- `LE`  output  1  latch gate/enable; driven directly from a flop, never decoded combinationally.
- `Busy`  output  1  high in every state except IDLE.
- `Done`  output  1  one-cycle pulse when a write sequence completes.

## Operation
- Reset values are asynchronous on `Rst`: state = IDLE, `D` = 0, `LE` = 0, `Done` = 0, `Busy` = 0, `In_Ready` = 1.
- The FSM has four states:
  - IDLE → SETUP on `In_Valid && In_Ready`. On this transition `D` <= `In_Data` and the phase timer loads `SETUP_CYC`−1.
  - SETUP → PULSE when the timer reaches 0. `LE` <= 1 and the timer loads `PULSE_CYC`−1.
  - PULSE → HOLD when the timer reaches 0. `LE` <= 0 and the timer loads `HOLD_CYC`−1.
  - HOLD → IDLE when the timer reaches 0. `Done` <= 1 for one cycle.
- `D` changes only on the IDLE→SETUP edge. It keeps its last value in IDLE; it does not return to 0.
- `In_Data` and `In_Valid` are ignored outside IDLE.
- In the IDLE cycle where `Done` is high, `In_Ready` = 1. A new word may be accepted in that same cycle (back-to-back, no bubble).
- Reset mid-sequence:
  - `LE` falls immediately and asynchronously, and `D` clears to 0.
  - No `Done` is produced; the interrupted word is discarded.
- Timer width is $clog2(max(`SETUP_CYC`,`PULSE_CYC`,`HOLD_CYC`)); minimum 1 bit. It is an unsigned down-counter with no wrap. It is reloaded only on a state transition.

## Timing
- Accept at rising edge k gives:
  - `D` valid from cycle k+1.
  - `LE` high for cycles k+1+`SETUP_CYC` through k+`SETUP_CYC`+`PULSE_CYC`.
  - HOLD for the next `HOLD_CYC` cycles.
  - `Done`/`In_Ready` high at cycle k+`SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+1.
- Throughput is one word per `SETUP_CYC`+`PULSE_CYC`+`HOLD_CYC`+1 cycles.
- `LE` toggles exactly twice per sequence and never glitches.
- `D` never changes while `LE` = 1 or in HOLD.

## Structure
- A shared package holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, PULSE=2'd2, HOLD=2'd3);
  - the timer-width function.
- One sub-module, `phase_timer`:
  - loadable down-counter with a `zero` flag;
  - instantiated once and shared across the three timed states.

## Test plan
- Defaults, `In_Data`=1 accepted at cycle 0:
  - `D`=1 from cycle 1;
  - `LE` high in cycles 3–6 only;
  - `Done` at cycle 9;
  - the bench's downstream 1-bit latch `Q` becomes 1 at cycle 3.
- `In_Valid` held high with alternating data (1, 0, 1): three sequences back-to-back with no gap; `D` changes only at cycles 0, 9, 18 (+1), and `Q` follows 1, 0, 1.
- `In_Data` toggled every cycle while `Busy`: `D` unchanged through SETUP/PULSE/HOLD; latched value equals the word sampled at accept.
- `Rst` pulsed at cycle 4 of a sequence (during PULSE): `LE`=0 and `D`=0 within the same cycle; no `Done`; `In_Ready`=1 after release.
- `WIDTH`=8, `SETUP_CYC`=`PULSE_CYC`=`HOLD_CYC`=1, word 8'hA5: `LE` high exactly cycle 2; `Done` at cycle 4.
- Checker on every run:
  - exactly one `LE` rising edge per `Done`;
  - `LE` high width = `PULSE_CYC`;
  - setup/hold cycle counts met.
